// File: rtl/fifo_uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx_pkg
// Shared types and constants for the FIFO-fed UART transmitter.
//   state_t         : transmitter FSM states
//   START_BIT       : line level of the start bit
//   STOP_BIT        : line level of the stop bit (also the idle level)
//   BITS_PER_BYTE   : data bits per 8N1 frame
//   FRAME_BITS      : start + data + stop bits per frame
//   bytes_per_word(): number of frames needed for one FIFO word
// -----------------------------------------------------------------------------
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } state_t;

  localparam logic START_BIT     = 1'b0;
  localparam logic STOP_BIT      = 1'b1;
  localparam int   BITS_PER_BYTE = 8;
  localparam int   FRAME_BITS    = 10;

  function automatic int bytes_per_word(input int dwidth);
    return dwidth / BITS_PER_BYTE;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx_if
// Read-side connection between a synchronous FIFO and its consumer.
//   fifo_empty : FIFO empty flag (FIFO -> consumer)
//   fifo_dout  : FIFO read data, valid the cycle after a pop (FIFO -> consumer)
//   fifo_rd_en : single-cycle pop strobe (consumer -> FIFO)
// Modports:
//   master : the consumer, which issues the pops
//   slave  : the FIFO read port
// -----------------------------------------------------------------------------
interface fifo_uart_tx_if #(
  parameter int DWIDTH = 16
) ();

  logic              fifo_empty;
  logic [DWIDTH-1:0] fifo_dout;
  logic              fifo_rd_en;

  modport master (
    input  fifo_empty,
    input  fifo_dout,
    output fifo_rd_en
  );

  modport slave (
    output fifo_empty,
    output fifo_dout,
    input  fifo_rd_en
  );

endinterface

// File: rtl/uart_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_bit_timer
// Free-running bit-period counter shared by the UART TX and RX sides.
//   clk     : system clock
//   rst     : synchronous active-high reset
//   restart : reload the counter to 0 on the next edge (state entry)
//   bit_end : high on the last cycle of each CLKS_PER_BIT-cycle bit period
// -----------------------------------------------------------------------------
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_end
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign bit_end = (cnt_q == CNT_LAST);

  // Wrapping at the end of a bit lets consecutive bits of the same state
  // share one timer without needing a restart.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (restart || bit_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
// Pops one DWIDTH-bit word from a registered-read FIFO whenever it is
// non-empty and sends it as DWIDTH/8 back-to-back 8N1 frames, low byte first.
//   clk        : system clock
//   rst        : synchronous active-high reset
//   fifo       : FIFO read port (master side: drives fifo_rd_en)
//   tx         : registered UART line, idle high
//   busy       : high whenever the FSM is not in IDLE
//   word_done  : one-cycle pulse on the last cycle of a word's final stop bit
// -----------------------------------------------------------------------------
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int DWIDTH       = 16,
  parameter int CLKS_PER_BIT = 104
) (
  input  logic           clk,
  input  logic           rst,
  fifo_uart_tx_if.master fifo,
  output logic           tx,
  output logic           busy,
  output logic           word_done
);

  localparam int NBYTES = bytes_per_word(DWIDTH);
  localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NBYTES - 1);
  localparam logic [2:0]        BIT_LAST  = 3'(BITS_PER_BYTE - 1);

  generate
    if ((DWIDTH % BITS_PER_BYTE) != 0 || DWIDTH < BITS_PER_BYTE) begin : g_bad_dwidth
      $error("fifo_uart_tx: DWIDTH must be a non-zero multiple of 8");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
      $error("fifo_uart_tx: CLKS_PER_BIT must be at least 2");
    end
  endgenerate

  state_t            state_q, state_d;
  logic [DWIDTH-1:0] word_q, word_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic [2:0]        bit_q, bit_d;
  logic              tx_q, tx_d;

  logic              bit_end;
  logic              restart;
  logic              rd_en;
  logic [DWIDTH-1:0] word_shift;

  // Popping only from IDLE keeps at most one word in flight; masking with
  // rst stops a pop on the reset cycle from losing a word.
  assign rd_en           = (state_q == IDLE) && !fifo.fifo_empty && !rst;
  assign fifo.fifo_rd_en = rd_en;

  assign tx        = tx_q;
  assign busy      = (state_q != IDLE);
  assign word_done = (state_q == STOP) && bit_end && (byte_q == BYTE_LAST);

  // Every state entry starts a fresh bit period.
  assign restart = (state_d != state_q);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .bit_end (bit_end)
  );

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    byte_d  = byte_q;
    bit_d   = bit_q;

    unique case (state_q)
      IDLE: begin
        if (rd_en) begin
          state_d = WAIT;
        end
      end
      // fifo_dout becomes valid during this cycle, one cycle after the pop.
      WAIT: begin
        word_d  = fifo.fifo_dout;
        byte_d  = '0;
        bit_d   = '0;
        state_d = START;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == BIT_LAST) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (byte_q == BYTE_LAST) begin
            state_d = IDLE;
          end else begin
            byte_d  = byte_q + BYTE_W'(1);
            bit_d   = '0;
            state_d = START;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The line level is decoded from the next-state values so tx comes
  // straight out of a flop and lines up with the state it belongs to.
  // {byte, bit} is exactly 8*byte + bit.
  assign word_shift = word_d >> {byte_d, bit_d};

  always_comb begin
    unique case (state_d)
      START:   tx_d = START_BIT;
      DATA:    tx_d = word_shift[0];
      default: tx_d = STOP_BIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      byte_q  <= '0;
      bit_q   <= '0;
      tx_q    <= STOP_BIT;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      byte_q  <= byte_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
// Two transmitters: A (DWIDTH=16, CLKS_PER_BIT=4) and B (DWIDTH=8,
// CLKS_PER_BIT=2). A queue-based FIFO model feeds each one; every popped word
// is pushed to an expected queue, and a line monitor per DUT decodes the UART
// stream and compares it against that queue.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;
  import fifo_uart_tx_pkg::*;

  localparam int DW_A       = 16;
  localparam int CPB_A      = 4;
  localparam int DW_B       = 8;
  localparam int CPB_B      = 2;
  localparam int WORD_CYC_A = (DW_A / 8) * FRAME_BITS * CPB_A;
  localparam int WORD_CYC_B = (DW_B / 8) * FRAME_BITS * CPB_B;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fifo_uart_tx_if #(.DWIDTH(DW_A)) if_a ();
  fifo_uart_tx_if #(.DWIDTH(DW_B)) if_b ();

  logic tx_a, busy_a, done_a;
  logic tx_b, busy_b, done_b;

  fifo_uart_tx #(.DWIDTH(DW_A), .CLKS_PER_BIT(CPB_A)) dut_a (
    .clk(clk), .rst(rst), .fifo(if_a), .tx(tx_a), .busy(busy_a), .word_done(done_a)
  );

  fifo_uart_tx #(.DWIDTH(DW_B), .CLKS_PER_BIT(CPB_B)) dut_b (
    .clk(clk), .rst(rst), .fifo(if_b), .tx(tx_b), .busy(busy_b), .word_done(done_b)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] fifo_a[$];
  logic [15:0] exp_a[$];
  logic [7:0]  fifo_b[$];
  logic [7:0]  exp_b[$];
  int          pop_log_a[$];
  int          pop_log_b[$];

  int words_a = 0, words_b = 0, aborts_a = 0, aborts_b = 0;
  int start_a = 0, start_b = 0, done_cyc_a = 0, done_cyc_b = 0;
  int stray_done = 0;

  function automatic logic line(input int sel);
    return (sel != 0) ? tx_b : tx_a;
  endfunction

  function automatic logic wdone(input int sel);
    return (sel != 0) ? done_b : done_a;
  endfunction

  function automatic int words_of(input int sel);
    return (sel != 0) ? words_b : words_a;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Line monitor: a frame starts at the first low sample on an idle line.
  // Every bit must hold one level for exactly cpb cycles; word_done must be
  // high only on the very last cycle of the last stop bit.
  task automatic monitor(input int sel);
    int nb, cpb, shape_err, done_err, avail;
    logic [15:0] word, e;
    logic v, bv, last_cyc;
    bit aborted;
    string pfx;
    pfx = (sel != 0) ? "b" : "a";
    nb  = (sel != 0) ? DW_B / 8 : DW_A / 8;
    cpb = (sel != 0) ? CPB_B : CPB_A;
    bv  = 1'b1;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 || line(sel) !== 1'b0) begin
        if (rst !== 1'b1 && wdone(sel) === 1'b1) stray_done++;
        continue;
      end
      if (sel != 0) start_b = cyc; else start_a = cyc;
      word = '0; shape_err = 0; done_err = 0; aborted = 0;
      for (int by = 0; by < nb && !aborted; by++) begin
        for (int k = 0; k < FRAME_BITS && !aborted; k++) begin
          for (int c = 0; c < cpb && !aborted; c++) begin
            if (by != 0 || k != 0 || c != 0) @(negedge clk);
            v = line(sel);
            if (c == 0) bv = v;
            else if (v !== bv) shape_err++;
            last_cyc = (by == nb - 1) && (k == FRAME_BITS - 1) && (c == cpb - 1);
            if (wdone(sel) !== last_cyc) done_err++;
            if (rst === 1'b1) aborted = 1;
          end
          if (!aborted) begin
            if (k == 0) begin
              if (bv !== START_BIT) shape_err++;
            end else if (k == FRAME_BITS - 1) begin
              if (bv !== STOP_BIT) shape_err++;
            end else begin
              word[8 * by + k - 1] = bv;
            end
          end
        end
      end
      if (aborted) begin
        // The popped word is lost on reset; drop its expectation.
        if (sel != 0) begin
          aborts_b++;
          if (exp_b.size() > 0) exp_b.delete(0);
        end else begin
          aborts_a++;
          if (exp_a.size() > 0) exp_a.delete(0);
        end
      end else begin
        if (sel != 0) done_cyc_b = cyc; else done_cyc_a = cyc;
        check({pfx, "_frame_shape_errors"}, shape_err, 0);
        check({pfx, "_word_done_position_errors"}, done_err, 0);
        avail = (sel != 0) ? exp_b.size() : exp_a.size();
        check({pfx, "_word_was_expected"}, 32'(avail != 0), 1);
        if (avail != 0) begin
          if (sel != 0) e = {8'h00, exp_b.pop_front()};
          else          e = exp_a.pop_front();
          check({pfx, "_word_data"}, word, e);
        end
        if (sel != 0) words_b++; else words_a++;
      end
    end
  endtask

  // One clock of the FIFO models: pops are decided from rd_en sampled at the
  // falling edge, and the popped word appears on dout just after the edge.
  task automatic step();
    logic pa, pb;
    @(negedge clk);
    pa = if_a.fifo_rd_en;
    pb = if_b.fifo_rd_en;
    if (pa === 1'b1) pop_log_a.push_back(cyc);
    if (pb === 1'b1) pop_log_b.push_back(cyc);
    @(posedge clk);
    #1;
    if (pa === 1'b1) begin
      check("a_pop_only_when_nonempty", 32'(fifo_a.size() != 0), 1);
      if (fifo_a.size() != 0) begin
        if_a.fifo_dout = fifo_a.pop_front();
        exp_a.push_back(if_a.fifo_dout);
      end
    end
    if (pb === 1'b1) begin
      check("b_pop_only_when_nonempty", 32'(fifo_b.size() != 0), 1);
      if (fifo_b.size() != 0) begin
        if_b.fifo_dout = fifo_b.pop_front();
        exp_b.push_back(if_b.fifo_dout);
      end
    end
    if_a.fifo_empty = (fifo_a.size() == 0);
    if_b.fifo_empty = (fifo_b.size() == 0);
  endtask

  task automatic push_a(input logic [15:0] w);
    fifo_a.push_back(w);
    if_a.fifo_empty = 1'b0;
  endtask

  task automatic push_b(input logic [7:0] w);
    fifo_b.push_back(w);
    if_b.fifo_empty = 1'b0;
  endtask

  task automatic wait_words(input int sel, input int target, input int budget);
    int n;
    n = 0;
    while (words_of(sel) < target && n < budget) begin
      step();
      n++;
    end
    check((sel != 0) ? "b_words_completed" : "a_words_completed", words_of(sel), target);
  endtask

  task automatic idle_check_a(input string tag, input int n);
    int bad;
    bad = 0;
    repeat (n) begin
      @(negedge clk);
      if (if_a.fifo_rd_en !== 1'b0 || tx_a !== 1'b1 || busy_a !== 1'b0) bad++;
      @(posedge clk);
      #1;
    end
    check(tag, bad, 0);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: got time limit, required self-termination");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0, ab0, np, n, p, d1, s2, cnt, rel;
    if_a.fifo_empty = 1'b1;
    if_a.fifo_dout  = '0;
    if_b.fifo_empty = 1'b1;
    if_b.fifo_dout  = '0;
    rst = 1'b1;
    fork
      monitor(0);
      monitor(1);
    join_none

    // Reset held with a word waiting: no pop, line idle, not busy.
    push_a(16'hA55A);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("a_rd_en_in_reset", if_a.fifo_rd_en, 0);
      check("a_tx_in_reset", tx_a, 1);
      check("a_busy_in_reset", busy_a, 0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    rel = cyc;

    // Single word 0xA55A: pop in the first cycle out of reset.
    step();
    check("a_pops_after_reset", pop_log_a.size(), 1);
    if (pop_log_a.size() > 0) check("a_first_pop_cycle", pop_log_a[0], rel);
    wait_words(0, 1, 200);
    if (pop_log_a.size() > 0) check("a_pop_to_start_latency", start_a - pop_log_a[0], 2);
    // word_done sits on the last framing cycle: start + 80 - 1.
    check("a_word_done_offset", done_cyc_a - start_a, WORD_CYC_A - 1);
    repeat (5) step();
    check("a_single_pop", pop_log_a.size(), 1);

    // Back-to-back words.
    np = pop_log_a.size();
    w0 = words_a;
    push_a(16'h0001);
    push_a(16'hFFFF);
    wait_words(0, w0 + 1, 300);
    d1 = done_cyc_a;
    wait_words(0, w0 + 2, 300);
    s2 = start_a;
    check("a_b2b_pop_count", pop_log_a.size(), np + 2);
    if (pop_log_a.size() >= np + 2)
      check("a_b2b_pop_spacing", pop_log_a[np + 1] - pop_log_a[np], WORD_CYC_A + 2);
    // Stop bit ends at d1+1; next start bit two cycles later.
    check("a_b2b_restart_gap", s2 - d1, 3);

    // Empty FIFO: nothing happens for 200 cycles.
    w0 = words_a;
    idle_check_a("a_idle_when_empty", 200);
    check("a_no_word_when_empty", words_a, w0);

    // Reset during DATA bit 3 of byte 0.
    w0  = words_a;
    ab0 = aborts_a;
    np  = pop_log_a.size();
    push_a(16'($urandom));
    n = 0;
    while (pop_log_a.size() == np && n < 10) begin
      step();
      n++;
    end
    check("a_pop_before_abort", pop_log_a.size(), np + 1);
    p = pop_log_a[pop_log_a.size() - 1];
    // Frame bit 4 (data bit 3) covers start+16 .. start+19.
    while (cyc < p + 2 + 4 * CPB_A + 1) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("a_tx_after_midframe_rst", tx_a, 1);
    check("a_busy_after_midframe_rst", busy_a, 0);
    @(posedge clk);
    #1;
    idle_check_a("a_idle_after_midframe_rst", 60);
    check("a_abort_seen", aborts_a, ab0 + 1);
    check("a_no_word_after_abort", words_a, w0);
    check("a_exp_empty_after_abort", exp_a.size(), 0);

    // Random words with random gaps on A.
    w0  = words_a;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      push_a(16'($urandom));
      cnt++;
      if ($urandom_range(0, 1) == 1) begin
        push_a(16'($urandom));
        cnt++;
      end
      repeat ($urandom_range(0, 120)) step();
    end
    wait_words(0, w0 + cnt, 2000);

    // DWIDTH=8, CLKS_PER_BIT=2, word 0x00: 20-cycle frame, 18 low + 2 high.
    push_b(8'h00);
    wait_words(1, 1, 100);
    if (pop_log_b.size() > 0) check("b_pop_to_start_latency", start_b - pop_log_b[0], 2);
    check("b_frame_len", done_cyc_b - start_b + 1, WORD_CYC_B);

    // Random bytes on B.
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      push_b(8'($urandom));
      cnt++;
      repeat ($urandom_range(0, 30)) step();
    end
    wait_words(1, 1 + cnt, 600);

    check("a_exp_queue_drained", exp_a.size(), 0);
    check("b_exp_queue_drained", exp_b.size(), 0);
    check("stray_word_done_pulses", stray_done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
